// File: rtl/pe_types_pkg.sv
// rtl/pe_types_pkg.sv - shared PE types: accumulate sideband, PE configuration record, defaults
package pe_types;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pe_accum_ctrl_t;

    typedef struct packed {
        int NUM_FEATURES;
        int NUM_FILTERS;
        int DOT_OUTPUT_WIDTH;
        int DOT_LATENCY;
    } pe_cfg_t;

    localparam int PE_ACCUM_WIDTH_DEFAULT = 32;

    localparam pe_cfg_t PE_CFG_DEFAULT = '{
        NUM_FEATURES:     2,
        NUM_FILTERS:      2,
        DOT_OUTPUT_WIDTH: 16,
        DOT_LATENCY:      3
    };

endpackage

// File: rtl/pe_ctrl_delay.sv
// rtl/pe_ctrl_delay.sv - fixed-depth shift register for accumulate control, with an OR of in-flight last bits
module pe_ctrl_delay
    import pe_types::*;
#(
    parameter int DEPTH = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  pe_accum_ctrl_t i_ctrl,
    output pe_accum_ctrl_t o_ctrl,
    output logic           o_last_pending
);

    if (DEPTH == 0) begin : g_bypass
        assign o_ctrl         = i_ctrl;
        assign o_last_pending = 1'b0;
    end else begin : g_shift
        pe_accum_ctrl_t r_stage [DEPTH];
        logic           w_pending;

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_ctrl;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        // Only a valid last counts: idle stages may carry stale flag bits after reset-free paths.
        always_comb begin
            w_pending = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                w_pending = w_pending | (r_stage[i].valid & r_stage[i].last);
            end
        end

        assign o_ctrl         = r_stage[DEPTH-1];
        assign o_last_pending = w_pending;
    end

endmodule

// File: rtl/pe_dot_accumulate.sv
// rtl/pe_dot_accumulate.sv - accumulates delayed dot results per group into a one-entry handshaked result buffer
// Optional PE_ACCUM_SATURATE_EN: each add clamps, and a clamped accumulator holds until its group ends.
module pe_dot_accumulate
    import pe_types::*;
#(
    parameter pe_cfg_t cfg         = PE_CFG_DEFAULT,
    parameter int      ACCUM_WIDTH = PE_ACCUM_WIDTH_DEFAULT
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  pe_accum_ctrl_t                       i_ctrl,
    output logic                                 o_ready,
    input  logic signed [cfg.DOT_OUTPUT_WIDTH-1:0] i_dot_result [cfg.NUM_FEATURES][cfg.NUM_FILTERS],
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic signed [ACCUM_WIDTH-1:0]        o_result [cfg.NUM_FEATURES][cfg.NUM_FILTERS],
    output logic                                 o_error
);

    localparam int NF  = cfg.NUM_FEATURES;
    localparam int NK  = cfg.NUM_FILTERS;
    localparam int DW  = cfg.DOT_OUTPUT_WIDTH;
    localparam int LAT = cfg.DOT_LATENCY;

    if (ACCUM_WIDTH < DW) begin : g_width_check
        $fatal(1, "pe_dot_accumulate: ACCUM_WIDTH must be >= cfg.DOT_OUTPUT_WIDTH");
    end

    pe_accum_ctrl_t w_d_ctrl;
    logic           w_last_pending;

    pe_ctrl_delay #(
        .DEPTH(LAT)
    ) u_ctrl_delay (
        .clock          (clock),
        .reset          (reset),
        .i_ctrl         (i_ctrl),
        .o_ctrl         (w_d_ctrl),
        .o_last_pending (w_last_pending)
    );

    logic signed [ACCUM_WIDTH-1:0] r_acc    [NF][NK];
    logic signed [ACCUM_WIDTH-1:0] r_result [NF][NK];
    logic signed [ACCUM_WIDTH-1:0] w_ext    [NF][NK];
    logic signed [ACCUM_WIDTH-1:0] w_base   [NF][NK];
    logic signed [ACCUM_WIDTH-1:0] w_next   [NF][NK];
    logic                          r_full;
    logic                          r_ready;
    logic                          r_error;

`ifdef PE_ACCUM_SATURATE_EN
    logic                          r_sat      [NF][NK];
    logic                          w_sat_next [NF][NK];
    logic        [ACCUM_WIDTH:0]   w_wide     [NF][NK];

    always_comb begin
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < NK; k++) begin
                w_ext[f][k]  = ACCUM_WIDTH'(i_dot_result[f][k]);
                w_base[f][k] = w_d_ctrl.first ? '0 : r_acc[f][k];
                w_wide[f][k] = {w_base[f][k][ACCUM_WIDTH-1], w_base[f][k]}
                             + {w_ext[f][k][ACCUM_WIDTH-1], w_ext[f][k]};
                if (!w_d_ctrl.first && r_sat[f][k]) begin
                    w_next[f][k]     = r_acc[f][k];
                    w_sat_next[f][k] = 1'b1;
                end else if (w_wide[f][k][ACCUM_WIDTH] != w_wide[f][k][ACCUM_WIDTH-1]) begin
                    // The extra sign bit tells which rail was crossed.
                    w_next[f][k]     = w_wide[f][k][ACCUM_WIDTH] ? {1'b1, {(ACCUM_WIDTH-1){1'b0}}}
                                                                 : {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
                    w_sat_next[f][k] = 1'b1;
                end else begin
                    w_next[f][k]     = w_wide[f][k][ACCUM_WIDTH-1:0];
                    w_sat_next[f][k] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < NK; k++) begin
                w_ext[f][k]  = ACCUM_WIDTH'(i_dot_result[f][k]);
                w_base[f][k] = w_d_ctrl.first ? '0 : r_acc[f][k];
                w_next[f][k] = w_base[f][k] + w_ext[f][k];
            end
        end
    end
`endif

    logic w_d_last;
    logic w_load;
    logic w_drop;
    logic w_full_next;
    logic w_in_last;

    assign w_d_last    = w_d_ctrl.valid & w_d_ctrl.last;
    assign w_load      = w_d_last & (~r_full | i_ready);
    assign w_drop      = w_d_last & r_full & ~i_ready;
    assign w_full_next = w_load | (r_full & ~i_ready);
    assign w_in_last   = i_ctrl.valid & i_ctrl.last;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int f = 0; f < NF; f++) begin
                for (int k = 0; k < NK; k++) begin
                    r_acc[f][k]    <= '0;
                    r_result[f][k] <= '0;
`ifdef PE_ACCUM_SATURATE_EN
                    r_sat[f][k]    <= 1'b0;
`endif
                end
            end
            r_full  <= 1'b0;
            r_ready <= 1'b1;
            r_error <= 1'b0;
        end else begin
            if (w_d_ctrl.valid) begin
                for (int f = 0; f < NF; f++) begin
                    for (int k = 0; k < NK; k++) begin
                        r_acc[f][k] <= w_d_ctrl.last ? '0 : w_next[f][k];
`ifdef PE_ACCUM_SATURATE_EN
                        r_sat[f][k] <= w_d_ctrl.last ? 1'b0 : w_sat_next[f][k];
`endif
                    end
                end
            end
            if (w_load) begin
                for (int f = 0; f < NF; f++) begin
                    for (int k = 0; k < NK; k++) begin
                        r_result[f][k] <= w_next[f][k];
                    end
                end
            end
            r_full <= w_full_next;
            // Hold off issue while a finished group could still be waiting for buffer space.
            r_ready <= ~w_full_next & ~w_last_pending & ~w_in_last;
            if (w_drop || (i_ctrl.valid && !r_ready)) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_full;
    assign o_error  = r_error;
    assign o_result = r_result;

endmodule

// File: doc/pe_dot_accumulate.md
# pe_dot_accumulate

Downstream stage of the packed DSP dot-product array. It consumes the per-(feature, filter) dot results, which arrive with fixed latency and carry no valid signal. It accumulates them across a variable-length group of dot beats (one group = one output pixel's full reduction) and presents each finished group as one wide result under a valid/ready handshake. Upstream issue is throttled so that completed results are never lost.

## Interface
Parameters:
- cfg, none, pe_cfg_t shared PE configuration. Uses NUM_FEATURES, NUM_FILTERS, DOT_OUTPUT_WIDTH and DOT_LATENCY.
- ACCUM_WIDTH, 32, accumulator and result width in bits. Must be ≥ cfg.DOT_OUTPUT_WIDTH; elaboration $fatal otherwise.

Ports:
- clock, in, 1, single clock for the block.
- reset, in, 1, synchronous, active-high.
- i_ctrl, in, pe_accum_ctrl_t {valid, first, last}, sideband aligned with the features/filters entering the dot stage in the same cycle.
- o_ready, out, 1, upstream may assert i_ctrl.valid only while this is high.
- i_dot_result, in, [cfg.DOT_OUTPUT_WIDTH-1:0] [NUM_FEATURES][NUM_FILTERS], signed dot results from the dot stage.
- o_valid, out, 1, result buffer holds a finished group.
- i_ready, in, 1, downstream accepts the result.
- o_result, out, [ACCUM_WIDTH-1:0] [NUM_FEATURES][NUM_FILTERS], finished sums, signed.
- o_error, out, 1, sticky protocol-violation flag.

## Operation
- The control delay line shifts i_ctrl by exactly cfg.DOT_LATENCY cycles, so the delayed control (d_ctrl) coincides with the matching i_dot_result.
- Every cycle with d_ctrl.valid, each accumulator updates:
  - acc = (d_ctrl.first ? 0 : acc) + sign_extend(dot).
  - The arithmetic is signed at ACCUM_WIDTH and wraps; the saturation option is under Configuration.
- first and last in the same beat form a one-beat group. The result is sign_extend(dot).
- When d_ctrl.last is set, acc + dot loads into the result buffer, o_valid sets, and the accumulators clear to 0.
- A d_ctrl.valid beat without first, following a completed group, adds to 0. This is legal.
- Result buffer states:
  - EMPTY: o_valid=0.
  - FULL: o_valid=1. Transitions to EMPTY on i_ready.
  - The buffer loads only in EMPTY, or in FULL on the same cycle as i_ready (simultaneous drain and load keeps it FULL with the new data).
- o_ready = !(buffer FULL and not draining) and no last pending in the delay line. With this rule a completed group always finds the buffer free.
- Protocol violations set o_error (cleared only by reset):
  - i_ctrl.valid while o_ready=0. The beat is still processed.
  - d_ctrl.last arriving with the buffer FULL and not draining. The new result is dropped and the buffer is kept.
- d_ctrl beats with valid=0 leave the accumulators unchanged.

## Timing
- Reset values:
  - o_valid=0, o_result=0, o_error=0, o_ready=1 (in the cycle after reset deasserts).
  - Accumulators 0, delay line all-zero.
- Reset mid-group discards the partial sums and any in-flight beats.
- Latency: a last beat issued at cycle t gives o_valid=1 at t+DOT_LATENCY+1.
- o_ready is registered: it falls the cycle after a last is issued, and rises the cycle after the buffer drains and no last is in flight.
- Throughput: one beat per cycle within a group. A new group's last beat cannot be issued until the previous result has drained.

## Configuration
- PE_ACCUM_SATURATE_EN defined: each add clamps to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1]. Once clamped, an accumulator stays saturated until its group ends.
- Undefined: two's-complement wrap, no extra logic.

## Structure
- Shared pe_types package:
  - pe_accum_ctrl_t packed struct {valid, first, last}.
  - PE_ACCUM_WIDTH_DEFAULT = 32.
- Sub-module pe_ctrl_delay: parameterised-depth shift register for pe_accum_ctrl_t with synchronous reset. It also exports an OR of the last bits held in its stages, which feeds o_ready.
- The accumulator array and the result buffer stay in pe_dot_accumulate.

## Test plan
- Single group: dot values 3, -5, 7 (first on beat 0, last on beat 2), i_ready=1 → o_result=5 at every index, o_valid pulses once at t2+DOT_LATENCY+1.
- One-beat group: first=last, dot=-1 → o_result=32'hFFFFFFFF, o_valid for 1 cycle.
- Backpressure: i_ready=0 after group A completes → o_ready stays low, o_result holds A. Raise i_ready → o_ready rises the next cycle, and a following group B produces the correct sum.
- Violation: issue a last while o_ready=0 with the buffer held → o_error=1 and buffer A is unchanged. o_error stays 1 until reset.
- Reset mid-group: 2 beats of 100, then reset, then a new one-beat group of 4 → result 4.
- Overflow, ACCUM_WIDTH=8 with DOT_OUTPUT_WIDTH ≤ 8, 3×100:
  - PE_ACCUM_SATURATE_EN defined → 127.
  - Undefined → 44 (300 mod 256).
